// File: rtl/fp32_add_unit.sv
// fp32_add_unit: IEEE-754 binary32 adder. Results are truncated toward zero,
// and subnormal operands are flushed to zero.
// The operation takes a fixed number of cycles:
//   IDLE (capture) -> ALIGN -> ADD -> NORM -> DONE -> outputs.
// data_valid_o rises 4 edges after the edge that captured the start strobe.
// Ports:
//   clk_i, rst_i (async, active-low)
//   data_valid_i, x_i, y_i        : start strobe and operands, sampled in IDLE
//   data_valid_o                  : one-cycle done pulse
//   z_o                           : result, held until the next completion
//   except_invalid_operation_o    : NaN operand or inf+inf (any signs)
//   except_overflow_o             : result exponent reached 255
module fp32_add_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_valid_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic        data_valid_o,
    output logic [31:0] z_o,
    output logic        except_invalid_operation_o,
    output logic        except_overflow_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned LZ_W   = 5;
    localparam int unsigned EXPN_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] x_q, y_q;
    logic              spec_q, spec_inv_q, sign_q, sub_q;
    logic [WORD_W-1:0] spec_z_q;
    logic [EXP_W-1:0]  exp_big_q;
    logic [SIG_W-1:0]  sig_big_q, sig_small_q;
    logic [SIG_W:0]    sum_q;
    logic [WORD_W-1:0] res_z_q;
    logic              res_inv_q, res_ovf_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; the start strobe only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (data_valid_i) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Unpack, classify, order and align the captured operands
    logic [EXP_W-1:0]  x_exp, y_exp, exp_small, exp_big, exp_shift;
    logic [FRAC_W-1:0] x_frac, y_frac;
    logic              x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, x_big;
    logic [SIG_W-1:0]  sig_big, sig_small, sig_small_al;
    logic              special, special_inv;
    logic [WORD_W-1:0] special_z;

    always_comb begin
        x_exp  = x_q[30:23];
        y_exp  = y_q[30:23];
        x_frac = x_q[22:0];
        y_frac = y_q[22:0];
        x_nan  = (x_exp == 8'hFF) && (x_frac != '0);
        y_nan  = (y_exp == 8'hFF) && (y_frac != '0);
        x_inf  = (x_exp == 8'hFF) && (x_frac == '0);
        y_inf  = (y_exp == 8'hFF) && (y_frac == '0);
        x_zero = (x_exp == '0);
        y_zero = (y_exp == '0);
        x_big  = (x_q[30:0] >= y_q[30:0]);

        exp_big   = x_big ? x_exp : y_exp;
        exp_small = x_big ? y_exp : x_exp;
        sig_big   = x_big ? {~x_zero, x_frac} : {~y_zero, y_frac};
        sig_small = x_big ? {~y_zero, y_frac} : {~x_zero, x_frac};
        exp_shift = exp_big - exp_small;
        // No guard/sticky: bits shifted past the LSB are simply lost
        sig_small_al = (exp_shift >= EXP_W'(SIG_W)) ? '0 : (sig_small >> exp_shift);

        special     = 1'b1;
        special_inv = 1'b0;
        special_z   = '0;
        if (x_nan || y_nan || (x_inf && y_inf)) begin
            special_inv = 1'b1;
            special_z   = 32'h7FFF_FFFF;
        end else if (x_inf) begin
            special_z = x_q;
        end else if (y_inf) begin
            special_z = y_q;
        end else if (x_zero) begin
            special_z = y_q;
        end else if (y_zero) begin
            special_z = x_q;
        end else begin
            special = 1'b0;
        end
    end

    // Normalize the magnitude sum and pack the result word
    logic [LZ_W-1:0]   lz;
    logic [EXPN_W-1:0] exp_n;
    logic [FRAC_W-1:0] frac_n;
    logic [WORD_W-1:0] res_z;
    logic              res_inv, res_ovf;

    always_comb begin
        lz = '0;
        for (int i = 0; i < int'(SIG_W); i++) begin
            if (sum_q[i]) lz = LZ_W'(int'(SIG_W) - 1 - i);
        end
        if (sum_q[SIG_W]) begin
            frac_n = sum_q[SIG_W-1:1];
            exp_n  = EXPN_W'(exp_big_q) + EXPN_W'(1);
        end else begin
            frac_n = FRAC_W'(sum_q[SIG_W-1:0] << lz);
            exp_n  = EXPN_W'(exp_big_q) - EXPN_W'(lz);
        end

        res_z   = '0;
        res_inv = 1'b0;
        res_ovf = 1'b0;
        if (spec_q) begin
            res_z   = spec_z_q;
            res_inv = spec_inv_q;
        end else if (sum_q == '0) begin
            res_z = '0;
        end else if (exp_n[EXPN_W-1] || (exp_n == '0)) begin
            // Exponent wrapped negative or hit zero: flush to signed zero
            res_z = {sign_q, 31'b0};
        end else if (exp_n >= EXPN_W'(255)) begin
            res_z   = {sign_q, 8'hFF, 23'b0};
            res_ovf = 1'b1;
        end else begin
            res_z = {sign_q, exp_n[EXP_W-1:0], frac_n};
        end
    end

    // Datapath registers, one stage loaded per state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            x_q                        <= '0;
            y_q                        <= '0;
            spec_q                     <= 1'b0;
            spec_inv_q                 <= 1'b0;
            spec_z_q                   <= '0;
            sign_q                     <= 1'b0;
            sub_q                      <= 1'b0;
            exp_big_q                  <= '0;
            sig_big_q                  <= '0;
            sig_small_q                <= '0;
            sum_q                      <= '0;
            res_z_q                    <= '0;
            res_inv_q                  <= 1'b0;
            res_ovf_q                  <= 1'b0;
            z_o                        <= '0;
            data_valid_o               <= 1'b0;
            except_invalid_operation_o <= 1'b0;
            except_overflow_o          <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        x_q <= x_i;
                        y_q <= y_i;
                    end
                end
                ST_ALIGN: begin
                    spec_q      <= special;
                    spec_inv_q  <= special_inv;
                    spec_z_q    <= special_z;
                    sign_q      <= x_big ? x_q[31] : y_q[31];
                    sub_q       <= x_q[31] ^ y_q[31];
                    exp_big_q   <= exp_big;
                    sig_big_q   <= sig_big;
                    sig_small_q <= sig_small_al;
                end
                ST_ADD: begin
                    // Big operand is never smaller, so the difference cannot wrap
                    sum_q <= sub_q ? ({1'b0, sig_big_q} - {1'b0, sig_small_q})
                                   : ({1'b0, sig_big_q} + {1'b0, sig_small_q});
                end
                ST_NORM: begin
                    res_z_q   <= res_z;
                    res_inv_q <= res_inv;
                    res_ovf_q <= res_ovf;
                end
                ST_DONE: begin
                    z_o                        <= res_z_q;
                    except_invalid_operation_o <= res_inv_q;
                    except_overflow_o          <= res_ovf_q;
                    data_valid_o               <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_add_unit.sv
// Directed-vector bench for fp32_add_unit.
module tb_fp32_add_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] x_i = '0;
    logic [31:0] y_i = '0;
    logic        data_valid_o;
    logic [31:0] z_o;
    logic        except_invalid_operation_o;
    logic        except_overflow_o;

    int checks = 0;
    int errors = 0;

    fp32_add_unit dut (
        .clk_i                      (clk_i),
        .rst_i                      (rst_i),
        .data_valid_i               (data_valid_i),
        .x_i                        (x_i),
        .y_i                        (y_i),
        .data_valid_o               (data_valid_o),
        .z_o                        (z_o),
        .except_invalid_operation_o (except_invalid_operation_o),
        .except_overflow_o          (except_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        inv;
        logic        ovf;
    } vec_t;

    localparam int N_ARITH = 14;
    localparam int N_SPEC  = 13;

    vec_t arith_v [N_ARITH] = '{
        '{32'h3fc00000, 32'h4500001a, 32'h4500181a, 1'b0, 1'b0},
        '{32'h484c3381, 32'h25acf030, 32'h484c3381, 1'b0, 1'b0},
        '{32'hc5fce001, 32'h34d98e63, 32'hc5fce001, 1'b0, 1'b0},
        '{32'hc3730083, 32'h41199999, 32'hc36966ea, 1'b0, 1'b0},
        '{32'h3f000000, 32'hbee00000, 32'h3d800000, 1'b0, 1'b0},
        '{32'h4479ff5c, 32'h3c23d70a, 32'h4479ffff, 1'b0, 1'b0},
        '{32'h431617a8, 32'hc3480000, 32'hc247a160, 1'b0, 1'b0},
        '{32'h4238147b, 32'hc21f36ae, 32'h40c6ee68, 1'b0, 1'b0},
        '{32'h3db8d4fe, 32'h3f68f9b1, 32'h3f800a28, 1'b0, 1'b0},
        '{32'h42c40666, 32'h41403333, 32'h42dc0ccc, 1'b0, 1'b0},
        '{32'h3f800000, 32'hbf800000, 32'h00000000, 1'b0, 1'b0},
        '{32'h80c00000, 32'h00a00000, 32'h80000000, 1'b0, 1'b0},
        '{32'h4b800000, 32'h3f800000, 32'h4b800000, 1'b0, 1'b0},
        '{32'h4b000000, 32'h3f800000, 32'h4b000001, 1'b0, 1'b0}
    };

    vec_t spec_v [N_SPEC] = '{
        '{32'h484c3381, 32'h00000000, 32'h484c3381, 1'b0, 1'b0},
        '{32'h4479ff5c, 32'h80000000, 32'h4479ff5c, 1'b0, 1'b0},
        '{32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0},
        '{32'h7f800000, 32'h4479ff5c, 32'h7f800000, 1'b0, 1'b0},
        '{32'h4479ff5c, 32'hff800000, 32'hff800000, 1'b0, 1'b0},
        '{32'hff800000, 32'hc21f36ae, 32'hff800000, 1'b0, 1'b0},
        '{32'h7f800000, 32'h7f800000, 32'h7fffffff, 1'b1, 1'b0},
        '{32'h7f800000, 32'hff800000, 32'h7fffffff, 1'b1, 1'b0},
        '{32'h3db8d4fe, 32'hffffffff, 32'h7fffffff, 1'b1, 1'b0},
        '{32'h7fffffff, 32'h7f800000, 32'h7fffffff, 1'b1, 1'b0},
        '{32'h7f61b1e6, 32'h7e348e52, 32'h7f800000, 1'b0, 1'b1},
        '{32'h7f6f4447, 32'h7e879ae3, 32'h7f800000, 1'b0, 1'b1},
        '{32'h7f7fffff, 32'h7cf0bdc2, 32'h7f800000, 1'b0, 1'b1}
    };

    // Issue one operation and watch 7 edges: pulse position, count, result, hold value
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] z, output logic inv, output logic ovf,
                          output int lat, output int np, output logic [31:0] zh);
        @(negedge clk_i);
        x_i = a;
        y_i = b;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        lat = 0;
        np  = 0;
        z   = z_o;
        inv = except_invalid_operation_o;
        ovf = except_overflow_o;
        zh  = z_o;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_i);
            #1;
            if (lat != 0 && k == lat + 1) zh = z_o;
            if (data_valid_o) begin
                np++;
                if (lat == 0) begin
                    lat = k;
                    z   = z_o;
                    inv = except_invalid_operation_o;
                    ovf = except_overflow_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({data_valid_o, except_invalid_operation_o, except_overflow_o} !== 3'b000 || z_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_active: valid/inv/ovf=%b%b%b z=%h, required 000 z=00000000",
                     data_valid_o, except_invalid_operation_o, except_overflow_o, z_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if ({data_valid_o, except_invalid_operation_o, except_overflow_o} !== 3'b000 || z_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: valid/inv/ovf=%b%b%b z=%h, required 000 z=00000000",
                     data_valid_o, except_invalid_operation_o, except_overflow_o, z_o);
        end
    endtask

    task automatic test_arith();
        logic [31:0] z, zh;
        logic        inv, ovf;
        int          lat, np;
        for (int i = 0; i < N_ARITH; i++) begin
            run_op(arith_v[i].x, arith_v[i].y, z, inv, ovf, lat, np, zh);
            checks++;
            if (z !== arith_v[i].z) begin
                errors++;
                $display("FAIL arith[%0d] z %h+%h: got %h required %h", i, arith_v[i].x, arith_v[i].y, z, arith_v[i].z);
            end
            checks++;
            if ({inv, ovf} !== {arith_v[i].inv, arith_v[i].ovf}) begin
                errors++;
                $display("FAIL arith[%0d] flags: got inv=%b ovf=%b required inv=%b ovf=%b", i, inv, ovf, arith_v[i].inv, arith_v[i].ovf);
            end
            checks++;
            if (lat != 4 || np != 1) begin
                errors++;
                $display("FAIL arith[%0d] latency: got edge %0d pulses %0d required edge 4 pulses 1", i, lat, np);
            end
            checks++;
            if (zh !== arith_v[i].z) begin
                errors++;
                $display("FAIL arith[%0d] hold: got %h required %h", i, zh, arith_v[i].z);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] z, zh;
        logic        inv, ovf;
        int          lat, np;
        for (int i = 0; i < N_SPEC; i++) begin
            run_op(spec_v[i].x, spec_v[i].y, z, inv, ovf, lat, np, zh);
            checks++;
            if (z !== spec_v[i].z) begin
                errors++;
                $display("FAIL special[%0d] z %h+%h: got %h required %h", i, spec_v[i].x, spec_v[i].y, z, spec_v[i].z);
            end
            checks++;
            if ({inv, ovf} !== {spec_v[i].inv, spec_v[i].ovf}) begin
                errors++;
                $display("FAIL special[%0d] flags: got inv=%b ovf=%b required inv=%b ovf=%b", i, inv, ovf, spec_v[i].inv, spec_v[i].ovf);
            end
            checks++;
            if (lat != 4 || np != 1) begin
                errors++;
                $display("FAIL special[%0d] latency: got edge %0d pulses %0d required edge 4 pulses 1", i, lat, np);
            end
            checks++;
            if (zh !== spec_v[i].z) begin
                errors++;
                $display("FAIL special[%0d] hold: got %h required %h", i, zh, spec_v[i].z);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] z, zh;
        logic        inv, ovf;
        int          lat, np;
        // Leave nonzero outputs behind so the reset clear is observable
        run_op(32'h7f800000, 32'h7f800000, z, inv, ovf, lat, np, zh);
        @(negedge clk_i);
        x_i = 32'h42c40666;
        y_i = 32'h41403333;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({data_valid_o, except_invalid_operation_o, except_overflow_o} !== 3'b000 || z_o !== 32'h0) begin
            errors++;
            $display("FAIL abort_clear: valid/inv/ovf=%b%b%b z=%h, required 000 z=00000000",
                     data_valid_o, except_invalid_operation_o, except_overflow_o, z_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i);
            #1;
            if (data_valid_o) np++;
        end
        checks++;
        if (np != 0 || z_o !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_pulse: got pulses %0d z=%h required pulses 0 z=00000000", np, z_o);
        end
        run_op(32'h42c40666, 32'h41403333, z, inv, ovf, lat, np, zh);
        checks++;
        if (z !== 32'h42dc0ccc || lat != 4 || np != 1) begin
            errors++;
            $display("FAIL abort_recover: got z=%h edge %0d pulses %0d required z=42dc0ccc edge 4 pulses 1", z, lat, np);
        end
    endtask

    task automatic test_ignore_busy();
        int          lat, np;
        logic [31:0] z;
        logic        inv;
        @(negedge clk_i);
        x_i = 32'h3f000000;
        y_i = 32'hbee00000;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        // Strobe stays high with different operands while busy
        x_i = 32'h7f800000;
        y_i = 32'h7f800000;
        lat = 0;
        np  = 0;
        z   = '0;
        inv = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 2) data_valid_i = 1'b0;
            if (data_valid_o) begin
                np++;
                if (lat == 0) begin
                    lat = k;
                    z   = z_o;
                    inv = except_invalid_operation_o;
                end
            end
        end
        checks++;
        if (z !== 32'h3d800000 || inv !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy result: got z=%h inv=%b required z=3d800000 inv=0", z, inv);
        end
        checks++;
        if (lat != 4 || np != 1) begin
            errors++;
            $display("FAIL ignore_busy pulses: got edge %0d pulses %0d required edge 4 pulses 1", lat, np);
        end
    endtask

    task automatic test_back_to_back();
        int          p1, p2, np;
        logic [31:0] z1, z2;
        @(negedge clk_i);
        x_i = 32'h3fc00000;
        y_i = 32'h4500001a;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        p1 = 0;
        p2 = 0;
        np = 0;
        z1 = '0;
        z2 = '0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_i);
            #1;
            if (data_valid_o) begin
                np++;
                if (p1 == 0) begin
                    p1 = k;
                    z1 = z_o;
                end else if (p2 == 0) begin
                    p2 = k;
                    z2 = z_o;
                end
            end
            if (k == 4) begin
                x_i = 32'hc3730083;
                y_i = 32'h41199999;
                data_valid_i = 1'b1;
            end else begin
                data_valid_i = 1'b0;
            end
        end
        checks++;
        if (z1 !== 32'h4500181a || z2 !== 32'hc36966ea) begin
            errors++;
            $display("FAIL back_to_back results: got %h,%h required 4500181a,c36966ea", z1, z2);
        end
        checks++;
        if (p1 != 4 || p2 != 9 || np != 2) begin
            errors++;
            $display("FAIL back_to_back timing: got edges %0d,%0d pulses %0d required 4,9 pulses 2", p1, p2, np);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_abort();
        test_ignore_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
